// File: rtl/sha_block_ctrl_if.sv
// Block-transfer interface for sha_block_ctrl.
// Carries the message-block handshake from the UART buffer and the
// block/strobe/digest signals exchanged with the SHA-256 core.
// slave  : the controller side.
// master : the environment side (block source plus core).
interface sha_block_ctrl_if;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;
    logic [511:0] core_block;
    logic         core_init;
    logic         core_next;
    logic         core_ready;
    logic [255:0] core_digest;

    modport slave (
        input  blk_data, blk_valid, blk_last, core_ready, core_digest,
        output blk_ready, core_block, core_init, core_next
    );

    modport master (
        output blk_data, blk_valid, blk_last, core_ready, core_digest,
        input  blk_ready, core_block, core_init, core_next
    );
endinterface

// File: rtl/sha_block_ctrl.sv
// sha_block_ctrl: sequences 512-bit message blocks into a SHA-256 core.
// A block is accepted only in IDLE while the core is idle. It is issued to
// the core with core_init (first block of a message) or core_next (later
// blocks). The final digest is latched once the last block completes.
// Optional feature: define SHA_CTRL_TIMEOUT_EN to enable a core watchdog
// that abandons the message after TIMEOUT_CYCLES cycles in GUARD/WAIT.
module sha_block_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sha_block_ctrl_if.slave   bus,
    output logic [255:0]      digest,
    output logic              digest_valid,
    output logic [15:0]       blk_cnt,
    output logic              err_overrun,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;

    logic         first_r;
    logic         last_r;
    logic [511:0] core_block_r;
    logic         core_init_r;
    logic         core_next_r;
    logic [255:0] digest_r;
    logic         digest_valid_r;
    logic [15:0]  blk_cnt_r;
    logic         err_overrun_r;
    logic         err_timeout_r;

    logic         blk_ready_s;
    logic         accept_s;
    logic         overrun_s;
    logic         core_done_s;
    logic         msg_done_s;
    logic         timeout_s;

    // blk_ready is combinational so the source sees core idleness immediately
    assign blk_ready_s = (state_r == ST_IDLE) && bus.core_ready;
    assign accept_s    = bus.blk_valid && blk_ready_s;
    assign overrun_s   = bus.blk_valid && !blk_ready_s;
    assign core_done_s = (state_r == ST_WAIT) && bus.core_ready;
    assign msg_done_s  = core_done_s && last_r;

`ifdef SHA_CTRL_TIMEOUT_EN
    localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Watchdog: counts cycles spent in GUARD/WAIT for the block in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_GUARD) || (state_r == ST_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // A core that finishes on the very last allowed cycle still wins
    assign timeout_s = (tmo_cnt_r == TMO_LAST) &&
                       ((state_r == ST_GUARD) ||
                        ((state_r == ST_WAIT) && !bus.core_ready));
`else
    // No watchdog in this build; TIMEOUT_CYCLES is referenced only so the
    // parameter stays part of the module's visible configuration.
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_GUARD;
            end
            ST_GUARD: begin
                if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.core_ready) begin
                    if (last_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Capture an accepted block and its last marker; held until the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_block_r <= 512'd0;
            last_r       <= 1'b0;
        end else if (accept_s) begin
            core_block_r <= bus.blk_data;
            last_r       <= bus.blk_last;
        end else begin
            core_block_r <= core_block_r;
            last_r       <= last_r;
        end
    end

    // Core strobes: registered at accept so they are high for the ISSUE cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_init_r <= 1'b0;
            core_next_r <= 1'b0;
        end else begin
            core_init_r <= accept_s && first_r;
            core_next_r <= accept_s && !first_r;
        end
    end

    // First-block flag: set when a message ends or is abandoned, cleared once issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_r <= 1'b1;
        end else if ((state_r == ST_DONE) || timeout_s) begin
            first_r <= 1'b1;
        end else if (state_r == ST_ISSUE) begin
            first_r <= 1'b0;
        end else begin
            first_r <= first_r;
        end
    end

    // Digest latch and pulse, both updated on the edge entering DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digest_r       <= 256'd0;
            digest_valid_r <= 1'b0;
        end else begin
            digest_valid_r <= msg_done_s;
            if (msg_done_s) begin
                digest_r <= bus.core_digest;
            end else begin
                digest_r <= digest_r;
            end
        end
    end

    // Block counter: restarts at 1 on a first block, saturates at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt_r <= 16'd0;
        end else if (accept_s) begin
            if (first_r) begin
                blk_cnt_r <= 16'd1;
            end else if (blk_cnt_r != 16'hFFFF) begin
                blk_cnt_r <= blk_cnt_r + 16'd1;
            end else begin
                blk_cnt_r <= blk_cnt_r;
            end
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    // Sticky error flags; only reset clears them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_overrun_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            err_overrun_r <= err_overrun_r | overrun_s;
            err_timeout_r <= err_timeout_r | timeout_s;
        end
    end

    assign bus.blk_ready  = blk_ready_s;
    assign bus.core_block = core_block_r;
    assign bus.core_init  = core_init_r;
    assign bus.core_next  = core_next_r;
    assign digest         = digest_r;
    assign digest_valid   = digest_valid_r;
    assign blk_cnt        = blk_cnt_r;
    assign err_overrun    = err_overrun_r;
    assign err_timeout    = err_timeout_r;

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Directed testbench for sha_block_ctrl. The bench plays both the block
// source and the SHA-256 core, presenting known digests when the core
// reports completion.
`timescale 1ns/1ps
module tb_sha_block_ctrl;

`ifdef SHA_CTRL_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 1024;
`endif

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] TWO_BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 64'h8000000000000000};
    localparam logic [511:0] TWO_BLK2 = {480'd0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] MID_DIG = {8{32'h5a5a1234}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] digest;
    logic         digest_valid;
    logic [15:0]  blk_cnt;
    logic         err_overrun;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;
    int dv_count = 0;
    int both_count = 0;

    sha_block_ctrl_if bus();

    sha_block_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .digest       (digest),
        .digest_valid (digest_valid),
        .blk_cnt      (blk_cnt),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // Monitor: digest_valid pulses and illegal simultaneous strobes
    always @(posedge clk) begin
        if (digest_valid === 1'b1) dv_count <= dv_count + 1;
        if ((bus.core_init === 1'b1) && (bus.core_next === 1'b1)) both_count <= both_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One block through the whole IDLE->ISSUE->GUARD->WAIT(->DONE) path
    task automatic run_block(input logic [511:0] data, input logic last,
                             input logic exp_init, input logic [15:0] exp_cnt,
                             input int lat, input logic [255:0] dig,
                             input logic inject, input string name);
        checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b expected 1", name, bus.blk_ready); end
        bus.blk_data = data; bus.blk_last = last; bus.blk_valid = 1'b1;
        step();
        bus.blk_valid = 1'b0; bus.blk_last = 1'b0;
        checks++; if ((bus.core_init !== exp_init) || (bus.core_next !== !exp_init)) begin errors++; $display("FAIL %s strobe got init=%b next=%b expected init=%b", name, bus.core_init, bus.core_next, exp_init); end
        checks++; if (bus.core_block !== data) begin errors++; $display("FAIL %s core_block got %h expected %h", name, bus.core_block, data); end
        checks++; if (blk_cnt !== exp_cnt) begin errors++; $display("FAIL %s blk_cnt got %0d expected %0d", name, blk_cnt, exp_cnt); end
        step();
        bus.core_ready = 1'b0;
        checks++; if ((bus.core_init !== 1'b0) || (bus.core_next !== 1'b0)) begin errors++; $display("FAIL %s strobe_width got init=%b next=%b expected 0", name, bus.core_init, bus.core_next); end
        step();
        for (int i = 0; i < lat; i++) begin
            if (inject && (i == 0)) begin
                checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL %s ready_busy got %b expected 0", name, bus.blk_ready); end
                bus.blk_data = ~data; bus.blk_last = 1'b1; bus.blk_valid = 1'b1;
            end
            step();
            bus.blk_valid = 1'b0; bus.blk_last = 1'b0;
            if (inject && (i == 0)) begin
                checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL %s err_overrun got %b expected 1", name, err_overrun); end
            end
        end
        checks++; if (bus.core_block !== data) begin errors++; $display("FAIL %s core_block_hold got %h expected %h", name, bus.core_block, data); end
        checks++; if ((bus.blk_ready !== 1'b0) || (digest_valid !== 1'b0)) begin errors++; $display("FAIL %s wait_outputs got ready=%b dv=%b expected 0 0", name, bus.blk_ready, digest_valid); end
        bus.core_digest = dig; bus.core_ready = 1'b1;
        step();
        if (last) begin
            checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL %s digest_valid got %b expected 1", name, digest_valid); end
            checks++; if (digest !== dig) begin errors++; $display("FAIL %s digest got %h expected %h", name, digest, dig); end
            step();
        end
        checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL %s dv_off got %b expected 0", name, digest_valid); end
        checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL %s ready_back got %b expected 1", name, bus.blk_ready); end
    endtask

    task automatic test_reset();
        bus.blk_data = 512'd0; bus.blk_valid = 1'b0; bus.blk_last = 1'b0;
        bus.core_ready = 1'b1; bus.core_digest = 256'd0;
        #1 rst = 1'b0;
        step(); step();
        checks++; if ((bus.core_init !== 1'b0) || (bus.core_next !== 1'b0) || (digest_valid !== 1'b0)) begin errors++; $display("FAIL reset_strobes got init=%b next=%b dv=%b expected 0", bus.core_init, bus.core_next, digest_valid); end
        checks++; if ((blk_cnt !== 16'd0) || (digest !== 256'd0) || (bus.core_block !== 512'd0)) begin errors++; $display("FAIL reset_data got cnt=%0d digest=%h expected 0", blk_cnt, digest); end
        checks++; if ((err_overrun !== 1'b0) || (err_timeout !== 1'b0)) begin errors++; $display("FAIL reset_errs got ovr=%b tmo=%b expected 0 0", err_overrun, err_timeout); end
        rst = 1'b1;
        step();
        checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", bus.blk_ready); end
        bus.core_ready = 1'b0; #1;
        checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL ready_core_busy got %b expected 0", bus.blk_ready); end
        bus.core_ready = 1'b1; #1;
    endtask

    task automatic test_single_block();
        int dv0 = dv_count;
        run_block(ABC_BLK, 1'b1, 1'b1, 16'd1, 4, ABC_DIG, 1'b0, "abc");
        checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL abc_cnt_hold got %0d expected 1", blk_cnt); end
        checks++; if (dv_count != dv0 + 1) begin errors++; $display("FAIL abc_dv_count got %0d expected %0d", dv_count - dv0, 1); end
    endtask

    task automatic test_two_block();
        run_block(TWO_BLK1, 1'b0, 1'b1, 16'd1, 5, MID_DIG, 1'b0, "two_b1");
        checks++; if (digest !== ABC_DIG) begin errors++; $display("FAIL two_mid_digest got %h expected %h", digest, ABC_DIG); end
        run_block(TWO_BLK2, 1'b1, 1'b0, 16'd2, 5, TWO_DIG, 1'b0, "two_b2");
        checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL two_cnt got %0d expected 2", blk_cnt); end
    endtask

    task automatic test_overrun();
        run_block(ABC_BLK, 1'b1, 1'b1, 16'd1, 3, ABC_DIG, 1'b1, "overrun");
        checks++; if ((err_overrun !== 1'b1) || (blk_cnt !== 16'd1)) begin errors++; $display("FAIL overrun_sticky got ovr=%b cnt=%0d expected 1 1", err_overrun, blk_cnt); end
    endtask

    task automatic test_reset_mid_message();
        run_block(TWO_BLK1, 1'b0, 1'b1, 16'd1, 2, MID_DIG, 1'b0, "rstmid_b1");
        bus.blk_data = TWO_BLK2; bus.blk_last = 1'b1; bus.blk_valid = 1'b1;
        step();
        bus.blk_valid = 1'b0; bus.blk_last = 1'b0;
        step();
        bus.core_ready = 1'b0;
        step(); step();
        #2 rst = 1'b0;
        #1;
        checks++; if ((blk_cnt !== 16'd0) || (bus.core_block !== 512'd0) || (digest !== 256'd0)) begin errors++; $display("FAIL rstmid_clear got cnt=%0d block_nz=%b digest_nz=%b expected 0", blk_cnt, |bus.core_block, |digest); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL rstmid_ovr got %b expected 0", err_overrun); end
        bus.core_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        run_block(ABC_BLK, 1'b1, 1'b1, 16'd1, 2, ABC_DIG, 1'b0, "rstmid_new");
    endtask

    task automatic test_back_to_back();
        int dv0 = dv_count;
        run_block(TWO_BLK2, 1'b1, 1'b1, 16'd1, 1, TWO_DIG, 1'b0, "b2b_m1");
        run_block(ABC_BLK, 1'b1, 1'b1, 16'd1, 1, ABC_DIG, 1'b0, "b2b_m2");
        checks++; if (dv_count != dv0 + 2) begin errors++; $display("FAIL b2b_dv_count got %0d expected 2", dv_count - dv0); end
    endtask

`ifdef SHA_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int dv0 = dv_count;
        bus.blk_data = ABC_BLK; bus.blk_last = 1'b1; bus.blk_valid = 1'b1;
        step();
        bus.blk_valid = 1'b0; bus.blk_last = 1'b0;
        step();
        bus.core_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b expected 0", err_timeout); end
        step();
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_set got %b expected 1", err_timeout); end
        bus.core_ready = 1'b1; #1;
        checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle got %b expected 1", bus.blk_ready); end
        step(); step();
        checks++; if (dv_count != dv0) begin errors++; $display("FAIL tmo_no_dv got %0d expected 0", dv_count - dv0); end
        run_block(ABC_BLK, 1'b1, 1'b1, 16'd1, 2, ABC_DIG, 1'b0, "tmo_after");
    endtask
`else
    task automatic test_wait_hold();
        run_block(TWO_BLK2, 1'b1, 1'b1, 16'd1, 40, TWO_DIG, 1'b0, "wait_hold");
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL wait_hold_tmo got %b expected 0", err_timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_two_block();
        test_overrun();
        test_reset_mid_message();
        test_back_to_back();
`ifdef SHA_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        step();
        checks++; if (both_count != 0) begin errors++; $display("FAIL init_next_together got %0d expected 0", both_count); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_block_ctrl.md
SHA_BLOCK_CTRL -- requirements
Module: sha_block_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: core watchdog limit in clk cycles (used only with SHA_CTRL_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 blk_data  input  512  message block from the UART buffer, byte 0 in bits [511:504].
REQ-005 blk_valid  input  1  blk_data holds a complete block (single-cycle pulse).
REQ-006 blk_last  input  1  qualifies blk_valid: block is the final padded block of its message.
REQ-007 blk_ready  output  1  controller can accept a block this cycle.
REQ-008 core_block  output  512  registered block presented to the SHA-256 core.
REQ-009 core_init  output  1  one-cycle pulse: start a new message with this block.
REQ-010 core_next  output  1  one-cycle pulse: continue the current message with this block.
REQ-011 core_ready  input  1  core idle; 0 while compressing.
REQ-012 core_digest  input  256  core hash state, valid when core_ready=1 after a block.
REQ-013 digest  output  256  latched final message digest.
REQ-014 digest_valid  output  1  one-cycle pulse: digest updated.
REQ-015 blk_cnt  output  16  blocks accepted for the current message.
REQ-016 err_overrun  output  1  sticky: blk_valid arrived while blk_ready=0.
REQ-017 err_timeout  output  1  sticky: core failed to finish within TIMEOUT_CYCLES.

Function
REQ-018 FSM states IDLE, ISSUE, GUARD, WAIT, DONE; reset state IDLE.
REQ-019 blk_ready = 1 only in IDLE with core_ready=1 (combinational from state and core_ready).
REQ-020 IDLE: blk_valid & blk_ready -> capture blk_data to core_block, store blk_last, go ISSUE next cycle.
REQ-021 ISSUE (1 cycle): pulse core_init if first-block flag set, else core_next; clear first-block flag; go GUARD.
REQ-022 GUARD (1 cycle): core_ready ignored (covers core ready-drop latency); go WAIT.
REQ-023 WAIT: on core_ready=1 -> DONE if stored last=1, else IDLE.
REQ-024 DONE (1 cycle): digest <= core_digest, digest_valid=1, first-block flag set, go IDLE.
REQ-025 Accept-to-core_init/next latency exactly 1 cycle; core done to digest_valid exactly 1 cycle.
REQ-026 blk_cnt: loads 1 on accepting a first block, increments on each later accepted block, saturates at 0xFFFF, holds after DONE until the next message starts.
REQ-027 blk_valid while blk_ready=0 -> block dropped, err_overrun set, FSM unaffected.
REQ-028 blk_valid with blk_last=1 on the first block -> single-block message, core_init then DONE.
REQ-029 core_init and core_next never asserted together; at most one pulse per accepted block.
REQ-030 core_block stable from ISSUE through WAIT.

Reset
REQ-031 rst=0 forces immediately: state IDLE, first-block flag 1, core_block 0, core_init/core_next 0, digest 0, digest_valid 0, blk_cnt 0, err_overrun 0, err_timeout 0.
REQ-032 Reset mid-message (any state) abandons the message; the next accepted block issues core_init.
REQ-033 Sticky error flags clear only by reset.

Configuration
REQ-034 Macro SHA_CTRL_TIMEOUT_EN defined: counter runs in GUARD/WAIT; at TIMEOUT_CYCLES cycles without core_ready -> err_timeout=1, first-block flag set, go IDLE, no digest_valid.
REQ-035 Macro undefined: no counter, err_timeout tied 0, WAIT holds indefinitely.

Verification
REQ-036 Single block "abc" padded (0x61626380..., length 0x18), last=1 -> core_init one cycle after accept, digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid 1 cycle, blk_cnt=1.
REQ-037 Two-block message "abcdbcde...nopq" -> core_init on block 1, core_next on block 2, digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, blk_cnt=2.
REQ-038 blk_valid pulsed during WAIT -> err_overrun=1, block ignored, in-flight digest still correct.
REQ-039 rst=0 during WAIT of block 2, then new single block -> core_init issued, blk_cnt=1.
REQ-040 With SHA_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, core_ready held 0 -> err_timeout=1 after 16 cycles, FSM IDLE, no digest_valid.
REQ-041 Back-to-back messages (last=1 then new block) -> second message uses core_init, digest_valid once per message.
